// File: rtl/sobel_pkg.sv
// Shared defaults, FSM state type and window packing helper
// for the Sobel 3x3 window generator.
package sobel_pkg;

    localparam int IMG_W_DEF = 1280;
    localparam int IMG_H_DEF = 720;
    localparam int DW_DEF    = 8;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // w[r][c] sits at DW*(8-(3r+c)): w00 in the MSBs, w22 in the LSBs
    function automatic int win_off(input int r, input int c, input int dw);
        return dw * (8 - (3 * r + c));
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-port row memory: combinational read, registered write,
// so a same-cycle read returns the old contents.
module sobel_line_buffer #(
    parameter int DEPTH = 1280,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DW-1:0]            wr_data_i,
    output logic [DW-1:0]            rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a column
// shift register, with a single output slot under valid/ready.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DW-1:0]            din,
    input  logic                     din_sof,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [9*DW-1:0]          win,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic                     frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] C_TWO  = CW'(2);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] R_TWO  = RW'(2);

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d, cur_c;
    logic [RW-1:0] row_q, row_d, cur_r;

    logic [DW-1:0] sr_q [3][2];
    logic [DW-1:0] sr_d [3][2];
    logic [DW-1:0] ncol [3];
    logic [DW-1:0] lb0_rd, lb1_rd;

    logic [9*DW-1:0] win_q, win_d, win_pk;
    logic [RW-1:0]   wrow_q, wrow_d;
    logic [CW-1:0]   wcol_q, wcol_d;
    logic            wvalid_q, wvalid_d;
    logic            fdone_q, fdone_d;

    logic accept, load, last_px;

    assign din_ready = !wvalid_q || win_ready;
    assign accept    = din_valid && din_ready;

    // SOF forces the accepted pixel to (0,0) whatever the counters say
    assign cur_c   = din_sof ? '0 : col_q;
    assign cur_r   = din_sof ? '0 : row_q;
    assign last_px = (cur_r == R_LAST) && (cur_c == C_LAST);
    assign load    = accept && (state_q == STREAM) &&
                     (cur_r >= R_TWO) && (cur_c >= C_TWO);

    sobel_line_buffer #(
        .DEPTH (IMG_W),
        .DW    (DW)
    ) u_lb0 (
        .clk       (clk),
        .we_i      (accept),
        .addr_i    (cur_c),
        .wr_data_i (din),
        .rd_data_o (lb0_rd)
    );

    sobel_line_buffer #(
        .DEPTH (IMG_W),
        .DW    (DW)
    ) u_lb1 (
        .clk       (clk),
        .we_i      (accept),
        .addr_i    (cur_c),
        .wr_data_i (lb0_rd),
        .rd_data_o (lb1_rd)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (cur_c == C_LAST) begin
                col_d = '0;
                row_d = (cur_r == R_LAST) ? '0 : cur_r + RW'(1);
            end else begin
                col_d = cur_c + CW'(1);
                row_d = cur_r;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: begin
                if (accept && cur_r == R_TWO && cur_c == '0) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept && (din_sof || last_px)) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // sr holds the two right-hand columns of the last window
    always_comb begin
        ncol[0] = lb1_rd;
        ncol[1] = lb0_rd;
        ncol[2] = din;
        win_pk  = '0;
        for (int r = 0; r < 3; r++) begin
            sr_d[r][0] = sr_q[r][1];
            sr_d[r][1] = ncol[r];
            win_pk[win_off(r, 0, DW) +: DW] = sr_q[r][0];
            win_pk[win_off(r, 1, DW) +: DW] = sr_q[r][1];
            win_pk[win_off(r, 2, DW) +: DW] = ncol[r];
        end
    end

    always_comb begin
        win_d    = win_q;
        wrow_d   = wrow_q;
        wcol_d   = wcol_q;
        wvalid_d = wvalid_q && !win_ready;
        fdone_d  = 1'b0;
        if (load) begin
            win_d    = win_pk;
            wrow_d   = cur_r - RW'(1);
            wcol_d   = cur_c - CW'(1);
            wvalid_d = 1'b1;
            fdone_d  = last_px;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            col_q    <= '0;
            row_q    <= '0;
            win_q    <= '0;
            wrow_q   <= '0;
            wcol_q   <= '0;
            wvalid_q <= 1'b0;
            fdone_q  <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    sr_q[r][c] <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            win_q    <= win_d;
            wrow_q   <= wrow_d;
            wcol_q   <= wcol_d;
            wvalid_q <= wvalid_d;
            fdone_q  <= fdone_d;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 2; c++) begin
                        sr_q[r][c] <= sr_d[r][c];
                    end
                end
            end
        end
    end

    assign win        = win_q;
    assign win_row    = wrow_q;
    assign win_col    = wcol_q;
    assign win_valid  = wvalid_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: frame-array reference model with an
// expected-window queue, directed frames plus random traffic.
module tb_sobel_window_gen;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = '0;
    logic        din_sof = 1'b0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [71:0] win;
    logic [1:0]  win_row;
    logic [2:0]  win_col;
    logic        win_valid;
    logic        win_ready = 1'b0;
    logic        frame_done;

    sobel_window_gen #(
        .IMG_W (W),
        .IMG_H (H),
        .DW    (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_sof    (din_sof),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .win        (win),
        .win_row    (win_row),
        .win_col    (win_col),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] w;
        int          r;
        int          c;
    } exp_t;

    exp_t q[$];
    int   img [H][W];
    int   mr = 0;
    int   mc = 0;
    bit   m_fd = 1'b0;
    int   nwin = 0;
    int   nfd = 0;
    int   nacc = 0;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string tag, input logic [71:0] got,
                         input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] mkwin(input int r, input int c);
        logic [71:0] v = '0;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
                v[8*(8-(3*rr+cc)) +: 8] = 8'(img[r-2+rr][c-2+cc]);
        return v;
    endfunction

    task automatic step(input bit dv, input int px, input bit sof,
                        input bit wr);
        bit ev, acc;
        int r, c;
        @(negedge clk);
        ev = (q.size() != 0);
        check("valid", 72'(win_valid), 72'(ev));
        check("fdone", 72'(frame_done), 72'(m_fd));
        if (frame_done) nfd++;
        din_valid = dv;
        din       = 8'(px);
        din_sof   = sof;
        win_ready = wr;
        #1;
        check("ready", 72'(din_ready), 72'(!ev || wr));
        if (ev && wr) begin
            check("win", win, q[0].w);
            check("row", 72'(win_row), 72'(q[0].r));
            check("col", 72'(win_col), 72'(q[0].c));
            void'(q.pop_front());
            nwin++;
        end
        acc  = dv && (!ev || wr);
        m_fd = 1'b0;
        if (acc) begin
            nacc++;
            r = sof ? 0 : mr;
            c = sof ? 0 : mc;
            img[r][c] = px & 255;
            if (r >= 2 && c >= 2) begin
                q.push_back('{mkwin(r, c), r - 1, c - 1});
                m_fd = (r == H - 1) && (c == W - 1);
            end
            if (c == W - 1) begin
                mc = 0;
                mr = (r == H - 1) ? 0 : r + 1;
            end else begin
                mc = c + 1;
                mr = r;
            end
        end
    endtask

    task automatic feed(input bit sof, input bit wr, input int base);
        step(1'b1, base + (sof ? 0 : 10 * mr + mc), sof, wr);
    endtask

    task automatic run_px(input int n, input int base);
        for (int i = 0; i < n; i++) feed(1'b0, 1'b1, base);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic rst_chk(input string tag);
        check({tag, "_valid"}, 72'(win_valid), 72'(0));
        check({tag, "_ready"}, 72'(din_ready), 72'(1));
        check({tag, "_fdone"}, 72'(frame_done), 72'(0));
        check({tag, "_win"}, win, 72'(0));
        check({tag, "_row"}, 72'(win_row), 72'(0));
        check({tag, "_col"}, 72'(win_col), 72'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        din_valid = 1'b0;
        win_ready = 1'b0;
        #1;
        rst_chk("rst_mid");
        q.delete();
        mr   = 0;
        mc   = 0;
        m_fd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int i, start;
        repeat (2) @(negedge clk);
        #1;
        rst_chk("rst");
        @(negedge clk);
        rst_n = 1'b1;

        nwin = 0; nfd = 0;
        run_px(W * H, 0);
        drain();
        check("a_nwin", 72'(nwin), 72'(6));
        check("a_nfd", 72'(nfd), 72'(1));

        nwin = 0; nfd = 0; start = nacc; i = 0;
        while (nacc - start < W * H && i < 100) begin
            feed(1'b0, !(i >= 13 && i < 16), 0);
            i++;
        end
        drain();
        check("b_nwin", 72'(nwin), 72'(6));
        check("b_nfd", 72'(nfd), 72'(1));

        nwin = 0; nfd = 0; i = 0;
        while (!(mr == 2 && mc == 1) && i < 100) begin
            feed(1'b0, 1'b1, 0);
            i++;
        end
        feed(1'b1, 1'b1, 100);
        run_px(W * H - 1, 100);
        drain();
        check("c_nwin", 72'(nwin), 72'(6));
        check("c_nfd", 72'(nfd), 72'(1));

        i = 0;
        while (!(mr == 3 && mc == 1) && i < 100) begin
            feed(1'b0, 1'b1, 0);
            i++;
        end
        do_reset();
        nwin = 0; nfd = 0;
        run_px(W * H, 50);
        drain();
        check("d_nwin", 72'(nwin), 72'(6));
        check("d_nfd", 72'(nfd), 72'(1));

        nwin = 0; nfd = 0;
        run_px(2 * W * H, 0);
        drain();
        check("e_nwin", 72'(nwin), 72'(12));
        check("e_nfd", 72'(nfd), 72'(2));

        for (int k = 0; k < 600; k++) begin
            step(($urandom % 4) != 0, int'($urandom % 256),
                 ($urandom % 60) == 0, ($urandom % 3) != 0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator that sits directly upstream of the Sobel convolution stage. It accepts one raster-order 8-bit pixel per handshake and keeps the two previous image rows in line buffers. It emits every fully-populated 3x3 neighbourhood as a packed 72-bit word, so the convolution never has to hold a frame in storage. Valid/ready handshakes on both sides allow backpressure from the convolution stage.

## Interface
- `IMG_W`, 1280, pixels per row (≥3)
- `IMG_H`, 720, rows per frame (≥3)
- `DW`, 8, pixel width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `din` in DW: input pixel, raster order
- `din_sof` in 1: qualifies the first pixel of a frame; sampled only on acceptance
- `din_valid` in 1: upstream pixel valid
- `din_ready` out 1: block can accept a pixel
- `win` out 9*DW: packed window; `w[r][c]` at `win[DW*(8-(3r+c)) +: DW]`, so `w00` is the MSBs (top-left) and `w22` is the LSBs (bottom-right)
- `win_row` out clog2(IMG_H): centre row of `win`
- `win_col` out clog2(IMG_W): centre column of `win`
- `win_valid` out 1: window valid
- `win_ready` in 1: downstream accepts the window
- `frame_done` out 1: one-cycle pulse, coincident with the first `win_valid` cycle of the frame's last window

## Operation
- Accept condition: `din_valid && din_ready`.
- `din_ready = !win_valid || win_ready` (a single output skid slot).
- Position counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) give the coordinates of the pixel being accepted.
  - `col` wraps to 0 at IMG_W-1 and `row` increments.
  - After (IMG_H-1, IMG_W-1) both counters return to 0.
- An accepted pixel with `din_sof=1` is treated as (0,0) regardless of counter state. The counters continue from (0,1).
- Line buffers:
  - `lb0[col]` holds row-1 and `lb1[col]` holds row-2.
  - On accept: read both at `col`, then write `lb1[col]<=lb0[col]` and `lb0[col]<=din` (read-before-write).
  - Buffers are not cleared on reset or SOF. Stale data is never exposed because validity is gated by position.
- Window shift register: on accept, shift columns left by one and insert the new right column `{lb1[col], lb0[col], din}` (top to bottom).
- Output generation:
  - Accepting a pixel at (r,c) with r≥2 and c≥2 loads the output register with the shifted window.
  - It also sets `win_row=r-1`, `win_col=c-1` and `win_valid=1`.
  - Accepting any other pixel produces no window.
- `win_valid` clears on `win_ready` unless a new window loads in the same cycle. Output fields hold stable while `win_valid && !win_ready`.
- Windows per frame: (IMG_W-2)*(IMG_H-2). Windows never straddle rows, because c<2 is suppressed.
- FSM `FILL` → `STREAM`:
  - `FILL` holds while row<2 and no windows are produced.
  - The transition to `STREAM` occurs on accepting (2,0).
  - `STREAM` returns to `FILL` after the last pixel of the frame, or on any SOF.

## Timing
- Reset values: `din_ready=1`, `win_valid=0`, `frame_done=0`, `win=0`, `win_row=0`, `win_col=0`, counters 0, state `FILL`.
- Latency: window registered 1 cycle after the accept of its bottom-right pixel.
- Throughput: 1 pixel/cycle with `win_ready` held high.
- Backpressure: `win_valid && !win_ready` forces `din_ready=0` in the same cycle, so no pixel is lost or overwritten.
- Simultaneous `win_ready` and a new accept: the new window replaces the old one and `win_valid` stays 1.
- Mid-frame SOF: the in-progress frame is abandoned and windows are produced again only from new row 2.
- Reset mid-frame: all state returns to reset values immediately. The first accepted pixel after reset is (0,0) even without SOF.

## Structure
- `sobel_pkg`: default IMG_W, IMG_H and DW; window index helper (`3r+c` to bit offset); FSM state enum (`FILL`, `STREAM`).
- Sub-module `sobel_line_buffer`: an IMG_W x DW single-port memory with read-before-write and a combinational read of `rd_data`. It is instantiated twice.

## Test plan
Parameters for all scenarios: IMG_W=5, IMG_H=4, pixel value = 10*r+c, with `win_ready` held at 1 unless stated otherwise.
- **First window:** stream pixels from reset → the first `win_valid` appears 1 cycle after accepting (2,2), with `w00=0`, `w11=11`, `w22=22`, `win_row=1`, `win_col=1`.
- **Window count and order:** stream a full frame → exactly 6 windows with centres (1,1),(1,2),(1,3),(2,1),(2,2),(2,3). `frame_done` fires with the (2,3) window only.
- **Backpressure:** drop `win_ready` for 3 cycles while windows are produced → `din_ready=0` during the stall and `win` holds stable. All 6 windows arrive with no duplicates or losses.
- **Mid-frame SOF:** assert SOF at old (2,1) → no window appears until new (2,2), and that window has `w00` equal to the new frame's (0,0) pixel.
- **Reset mid-frame:** deassert `rst_n` at (3,1) → outputs go to their reset values. The next frame yields exactly 6 correct windows.
- **Back-to-back frames:** stream two frames without SOF → 12 windows and 2 `frame_done` pulses. The second frame's first window is centred at (1,1) with correct data.
